// File: rtl/cpu_pkg.sv
// cpu_pkg: access-size encodings, load/store unit state type and word geometry
// shared by the load/store unit and its lane aligner.
package cpu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int WORD_BYTES = 4;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: extracts and extends load lanes from a memory word and
// merges sub-word store data into the old word for read-modify-write.
module lsu_lane_align
    import cpu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);
    logic [4:0]  w_byte_shift;
    logic [4:0]  w_half_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;
    logic [31:0] w_ins;
    always_comb begin
        w_byte_shift = {i_offset, 3'b000};
        w_half_shift = {i_offset[1], 4'b0000};
        w_byte = 8'(i_word >> w_byte_shift);
        w_half = 16'(i_word >> w_half_shift);
        o_load_data = (i_size == SZ_BYTE) ? {{24{~i_unsigned & w_byte[7]}}, w_byte}
                    : (i_size == SZ_HALF) ? {{16{~i_unsigned & w_half[15]}}, w_half}
                    : i_word;
        w_mask = (i_size == SZ_BYTE) ? 32'h0000_00FF << w_byte_shift : 32'h0000_FFFF << w_half_shift;
        w_ins = (i_size == SZ_BYTE) ? {24'b0, i_wdata[7:0]} << w_byte_shift
              : {16'b0, i_wdata[15:0]} << w_half_shift;
        o_store_word = (i_size == SZ_WORD) ? i_wdata : (i_word & ~w_mask) | w_ins;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word-wide Data_Memory,
// sub-word stores by read-modify-write. LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int DMEM_WORDS = 1024,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);
    localparam int OFF_W = $clog2(WORD_BYTES);
    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_we;
    logic              r_unsigned;
    logic              r_err;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic              w_accept;
    logic              w_size_err;
    logic              w_range_err;
    logic              w_err;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_load_data;
    logic [31:0]       w_store_word;

    assign w_accept    = req_valid && r_state == IDLE;
    assign w_size_err  = req_size == 2'b11;
    assign w_range_err = {{OFF_W{1'b0}}, req_addr[ADDR_W-1:OFF_W]} >= ADDR_W'(DMEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    assign w_addr     = req_addr;
    assign w_err      = w_size_err || w_range_err || w_misalign;
`else
    // Misaligned low bits are dropped so the access snaps to its natural boundary.
    assign w_addr = {req_addr[ADDR_W-1:2], req_addr[1] & (req_size != SZ_WORD), req_addr[0] & (req_size == SZ_BYTE)};
    assign w_err  = w_size_err || w_range_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_size     <= '0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
            r_word     <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= w_addr;
                r_size     <= req_size;
                r_we       <= req_we;
                r_unsigned <= req_unsigned;
                r_err      <= w_err;
                r_wdata    <= req_wdata;
            end
            if (r_state == READ) r_word <= mem_rd;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_err ? RESP : (req_we && req_size == SZ_WORD) ? WRITE : READ;
            READ:    w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    lsu_lane_align u_align (
        .i_word       (r_word),
        .i_offset     (r_addr[1:0]),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_comb begin
        req_ready = r_state == IDLE;
        rsp_valid = r_state == RESP;
        rsp_err   = rsp_valid && r_err;
        rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_load_data : 32'h0;
        mem_we    = r_state == WRITE;
        mem_a     = (r_state == READ || r_state == WRITE) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
        mem_wd    = mem_we ? w_store_word : 32'h0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store traffic against a byte-array
// memory model, with a word array standing in for Data_Memory.
module tb_load_store_unit;
    import cpu_pkg::*;
    localparam int DW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int failures = 0;

    logic [31:0] dmem [DW];
    logic [7:0]  ref_bytes [DW*4];

    logic        got;
    int          lat;
    int          we_cnt;
    logic [31:0] o_data;
    logic        o_err;
    logic [31:0] wa;
    logic [31:0] wdv;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwe;
    logic [31:0] exp_wa;

    always #5 clk = ~clk;

    load_store_unit #(.DMEM_WORDS(DW), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    assign mem_rd = dmem[mem_a[11:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DW; i++) dmem[i] <= '0;
        end else if (mem_we) begin
            dmem[mem_a[11:2]] <= mem_wd;
        end
    end

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    // Reference: the memory is a flat byte array; an access touches n consecutive bytes.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd);
        int n;
        int ea;
        logic mis;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis = (a % n) != 0;
        exp_err = (sz == 2'd3) || ((a >> 2) >= DW);
`ifdef LSU_MISALIGN_TRAP_EN
        exp_err = exp_err || mis;
        ea = int'(a);
`else
        ea = int'(a - a % n);
`endif
        exp_data = 0;
        exp_nwe = 0;
        exp_lat = 1;
        exp_wa = 0;
        if (!exp_err && we) begin
            for (int i = 0; i < n; i++) ref_bytes[ea+i] = wd[8*i +: 8];
            exp_nwe = 1;
            exp_lat = (n == 4) ? 2 : 3;
            exp_wa = 32'(ea) & ~32'd3;
        end else if (!exp_err) begin
            for (int i = 0; i < n; i++) exp_data = exp_data | (32'(ref_bytes[ea+i]) << (8*i));
            if (!uns && n < 4 && exp_data[8*n-1]) exp_data = exp_data | (32'hFFFF_FFFF << (8*n));
            exp_lat = 2;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                          input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0;
        lat = 99;
        we_cnt = 0;
        o_data = 0;
        o_err = 0;
        wa = 0;
        wdv = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                wa = mem_a;
                wdv = mem_wd;
            end
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
                o_data = rsp_rdata;
                o_err = rsp_err;
            end
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd);
        model(we, sz, uns, a, wd);
        do_req(we, sz, uns, a, wd);
    endtask

    task automatic test_reset;
        for (int i = 0; i < DW*4; i++) ref_bytes[i] = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_wd !== 32'h0) begin failures++; $display("FAIL reset_mem_wd got=%h exp=0", mem_wd); end
        clr = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_word_store_load;
        xact(1'b1, SZ_WORD, 1'b0, 32'h4, 32'h1234_5678);
        checks++; if (we_cnt !== 1) begin failures++; $display("FAIL ws_we_pulses got=%0d exp=1", we_cnt); end
        checks++; if (wa !== 32'h4) begin failures++; $display("FAIL ws_mem_a got=%h exp=00000004", wa); end
        checks++; if (wdv !== 32'h1234_5678) begin failures++; $display("FAIL ws_mem_wd got=%h exp=12345678", wdv); end
        checks++; if (lat !== 2 || o_err !== 1'b0 || o_data !== 32'h0) begin failures++; $display("FAIL ws_rsp lat=%0d err=%b data=%h exp lat=2 err=0 data=0", lat, o_err, o_data); end
        xact(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
        checks++; if (o_data !== 32'h1234_5678) begin failures++; $display("FAIL wl_data got=%h exp=12345678", o_data); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL wl_latency got=%0d exp=2", lat); end
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL wl_no_write got=%0d exp=0", we_cnt); end
    endtask

    task automatic test_byte_rmw;
        xact(1'b1, SZ_WORD, 1'b0, 32'h4, 32'hAABB_CCDD);
        xact(1'b1, SZ_BYTE, 1'b0, 32'h6, 32'hFFFF_FF11);
        checks++; if (wdv !== 32'hAA11_CCDD) begin failures++; $display("FAIL rmw_mem_wd got=%h exp=aa11ccdd", wdv); end
        checks++; if (lat !== 3 || we_cnt !== 1) begin failures++; $display("FAIL rmw_timing lat=%0d we=%0d exp lat=3 we=1", lat, we_cnt); end
        checks++; if (dmem[1] !== 32'hAA11_CCDD) begin failures++; $display("FAIL rmw_memory got=%h exp=aa11ccdd", dmem[1]); end
    endtask

    task automatic test_load_ext;
        xact(1'b0, SZ_BYTE, 1'b0, 32'h7, 32'h0);
        checks++; if (o_data !== 32'hFFFF_FFAA) begin failures++; $display("FAIL lb_signed got=%h exp=ffffffaa", o_data); end
        xact(1'b0, SZ_BYTE, 1'b1, 32'h7, 32'h0);
        checks++; if (o_data !== 32'h0000_00AA) begin failures++; $display("FAIL lb_unsigned got=%h exp=000000aa", o_data); end
        xact(1'b0, SZ_HALF, 1'b0, 32'h4, 32'h0);
        checks++; if (o_data !== 32'hFFFF_CCDD) begin failures++; $display("FAIL lh_signed got=%h exp=ffffccdd", o_data); end
        xact(1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0);
        checks++; if (o_data !== 32'hFFFF_AA11) begin failures++; $display("FAIL lh_upper got=%h exp=ffffaa11", o_data); end
        xact(1'b0, SZ_BYTE, 1'b0, 32'h6, 32'h0);
        checks++; if (o_data !== 32'h0000_0011) begin failures++; $display("FAIL lb_positive got=%h exp=00000011", o_data); end
    endtask

    task automatic test_errors;
        xact(1'b1, 2'b11, 1'b0, 32'h8, 32'hDEAD_BEEF);
        checks++; if (o_err !== 1'b1 || we_cnt !== 0 || o_data !== 32'h0) begin failures++; $display("FAIL size11 err=%b we=%0d data=%h exp err=1 we=0 data=0", o_err, we_cnt, o_data); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL err_latency got=%0d exp=1", lat); end
        xact(1'b0, SZ_WORD, 1'b0, DW*4, 32'h0);
        checks++; if (o_err !== 1'b1 || o_data !== 32'h0) begin failures++; $display("FAIL range_load err=%b data=%h exp err=1 data=0", o_err, o_data); end
        xact(1'b1, SZ_BYTE, 1'b0, DW*4, 32'h55);
        checks++; if (o_err !== 1'b1 || we_cnt !== 0) begin failures++; $display("FAIL range_store err=%b we=%0d exp err=1 we=0", o_err, we_cnt); end
        xact(1'b1, SZ_WORD, 1'b0, DW*4-4, 32'h0BAD_F00D);
        checks++; if (o_err !== 1'b0 || wa !== DW*4-4) begin failures++; $display("FAIL last_word err=%b mem_a=%h exp err=0 mem_a=%h", o_err, wa, DW*4-4); end
    endtask

    task automatic test_misalign;
        xact(1'b0, SZ_WORD, 1'b0, 32'h5, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (o_err !== 1'b1 || o_data !== 32'h0) begin failures++; $display("FAIL misalign_word err=%b data=%h exp err=1 data=0", o_err, o_data); end
`else
        checks++; if (o_err !== 1'b0 || o_data !== 32'hAA11_CCDD) begin failures++; $display("FAIL misalign_word err=%b data=%h exp err=0 data=aa11ccdd", o_err, o_data); end
`endif
        xact(1'b1, SZ_HALF, 1'b0, 32'h5, 32'h0000_7E7E);
        checks++; if (o_err !== exp_err || we_cnt !== exp_nwe) begin failures++; $display("FAIL misalign_half err=%b we=%0d exp err=%b we=%0d", o_err, we_cnt, exp_err, exp_nwe); end
        checks++; if (dmem[1] !== ref_word(1)) begin failures++; $display("FAIL misalign_mem got=%h exp=%h", dmem[1], ref_word(1)); end
    endtask

    task automatic test_handshake;
        int acc;
        int rsp;
        acc = 0;
        rsp = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_size = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr = 32'h4;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) acc++;
            if (rsp_valid) begin
                rsp++;
                checks++; if (req_ready !== 1'b0 || rsp_rdata !== ref_word(1)) begin failures++; $display("FAIL hs_resp ready=%b data=%h exp ready=0 data=%h", req_ready, rsp_rdata, ref_word(1)); end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) rsp++;
            @(negedge clk);
        end
        checks++; if (acc !== 4) begin failures++; $display("FAIL hs_accepts got=%0d exp=4", acc); end
        checks++; if (rsp !== acc) begin failures++; $display("FAIL hs_pulses got=%0d exp=%0d", rsp, acc); end
    endtask

    task automatic test_reset_mid_write;
        logic seen;
        xact(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = SZ_BYTE;
        req_addr = 32'h21;
        req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = mem_we;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rst_reach_write got=%b exp=1", seen); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_a !== 32'h0) begin failures++; $display("FAIL rst_async mem_we=%b mem_a=%h exp 0/0", mem_we, mem_a); end
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_idle ready=%b rsp=%b exp 1/0", req_ready, rsp_valid); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_no_rsp got=%b exp=0", seen); end
        checks++; if (dmem[8] !== 32'hCAFE_F00D) begin failures++; $display("FAIL rst_word_kept got=%h exp=cafef00d", dmem[8]); end
    endtask

    task automatic test_random;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom);
            sz = 2'($urandom);
            uns = 1'($urandom);
            wd = $urandom;
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) a = DW*4 - 4 + $urandom_range(0, 7);
            xact(we, sz, uns, a, wd);
            checks++; if (o_err !== exp_err || o_data !== exp_data || lat !== exp_lat || we_cnt !== exp_nwe) begin
                failures++;
                $display("FAIL rnd_%0d we=%b sz=%0d a=%h got err=%b data=%h lat=%0d wes=%0d exp err=%b data=%h lat=%0d wes=%0d",
                         t, we, sz, a, o_err, o_data, lat, we_cnt, exp_err, exp_data, exp_lat, exp_nwe);
            end
            if (exp_nwe == 1) begin
                checks++; if (wa !== exp_wa || wdv !== ref_word(int'(exp_wa >> 2))) begin failures++; $display("FAIL rnd_wr_%0d mem_a=%h wd=%h exp mem_a=%h wd=%h", t, wa, wdv, exp_wa, ref_word(int'(exp_wa >> 2))); end
            end
        end
        for (int w = 0; w < 16; w++) begin
            checks++; if (dmem[w] !== ref_word(w)) begin failures++; $display("FAIL rnd_mem_%0d got=%h exp=%h", w, dmem[w], ref_word(w)); end
        end
        checks++; if (dmem[DW-1] !== ref_word(DW-1)) begin failures++; $display("FAIL rnd_mem_top got=%h exp=%h", dmem[DW-1], ref_word(DW-1)); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_load_ext();
        test_errors();
        test_misalign();
        test_handshake();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
